// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared state encoding, defaults and helpers for the bus fabric
// Contents: bus_state_t (IDLE/ACCESS/RESP), DEFAULT_ERR_RDATA, clog2(),
//           RISCV_BUS_PACK3 macro to build base/mask vectors (slave 0 in LSBs).
package riscv_bus_pkg;
`define RISCV_BUS_PACK3(s0, s1, s2) {s2, s1, s0}
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/riscv_bus_fabric_if.sv
// riscv_bus_fabric_if: core-side and slave-side bus bundle of the fabric
// Core side : m_req, m_addr, m_wdata, m_write_w/h/b -> fabric; m_rdata, m_ack,
//             m_err, err_addr <- fabric.
// Slave side: s_cs, s_addr, s_wdata, s_write_w/h/b <- fabric; s_rdata (packed,
//             slave 0 in LSBs), s_ready -> fabric.
// Modport slave is the fabric's view; modport master is the core/slaves view.
interface riscv_bus_fabric_if #(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int NR_OF_SLAVES   = 4
);
  logic                         m_req;
  logic [ADDR_BUS_WIDTH-1:0]    m_addr;
  logic [31:0]                  m_wdata;
  logic                         m_write_w;
  logic                         m_write_h;
  logic                         m_write_b;
  logic [31:0]                  m_rdata;
  logic                         m_ack;
  logic                         m_err;
  logic [ADDR_BUS_WIDTH-1:0]    err_addr;
  logic [NR_OF_SLAVES-1:0]      s_cs;
  logic [ADDR_BUS_WIDTH-1:0]    s_addr;
  logic [31:0]                  s_wdata;
  logic                         s_write_w;
  logic                         s_write_h;
  logic                         s_write_b;
  logic [NR_OF_SLAVES*32-1:0]   s_rdata;
  logic [NR_OF_SLAVES-1:0]      s_ready;
  modport slave (
    input  m_req, m_addr, m_wdata, m_write_w, m_write_h, m_write_b,
    output m_rdata, m_ack, m_err, err_addr,
    output s_cs, s_addr, s_wdata, s_write_w, s_write_h, s_write_b,
    input  s_rdata, s_ready
  );
  modport master (
    output m_req, m_addr, m_wdata, m_write_w, m_write_h, m_write_b,
    input  m_rdata, m_ack, m_err, err_addr,
    input  s_cs, s_addr, s_wdata, s_write_w, s_write_h, s_write_b,
    output s_rdata, s_ready
  );
endinterface

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational first-match base/mask address decoder
// Ports: addr, base/mask (packed, slave 0 in LSBs) in; hit, sel (index of the
//        lowest matching slave) and onehot out.
module bus_addr_decode #(
  parameter int AW    = 16,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [AW-1:0]   addr,
  input  logic [N*AW-1:0] base,
  input  logic [N*AW-1:0] mask,
  output logic            hit,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]    onehot
);
  // Scan from the top index down so the lowest matching index is written last.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--)
      if ((addr & mask[i*AW +: AW]) == base[i*AW +: AW]) begin
        hit       = 1'b1;
        sel       = SEL_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
  end
endmodule

// File: rtl/riscv_bus_fabric.sv
// riscv_bus_fabric: table-decoded single-master bus fabric with wait states and timeout
// Ports: clk, rst (async active-low) and bus (riscv_bus_fabric_if.slave) carrying
//        the core request/response and the shared slave-side select/data signals.
module riscv_bus_fabric
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH    = 16,
  parameter int NR_OF_SLAVES      = 4,
  parameter logic [NR_OF_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NR_OF_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CNT_WIDTH = 4,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input logic               clk,
  input logic               rst,
  riscv_bus_fabric_if.slave bus
);
  localparam int SEL_W = (clog2(NR_OF_SLAVES) > 0) ? clog2(NR_OF_SLAVES) : 1;
  // Counter value on the last ACCESS cycle before the timeout fires.
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] CNT_LAST =
    TIMEOUT_CNT_WIDTH'((1 << TIMEOUT_CNT_WIDTH) - 2);
  bus_state_t                    state, state_nx;
  logic                          dec_hit;
  logic [SEL_W-1:0]              dec_sel, sel_q;
  logic [NR_OF_SLAVES-1:0]       dec_onehot, cs_q, cs_act;
  logic [ADDR_BUS_WIDTH-1:0]     addr_q, err_addr_q;
  logic [31:0]                   wdata_q, rdata_q, rdata_sel;
  logic [2:0]                    wr_q;
  logic                          err_q;
  logic [TIMEOUT_CNT_WIDTH-1:0]  cnt_q;
  logic                          start, ready, tmo;
  bus_addr_decode #(
    .AW   (ADDR_BUS_WIDTH),
    .N    (NR_OF_SLAVES),
    .SEL_W(SEL_W)
  ) u_dec (
    .addr  (bus.m_addr),
    .base  (SLAVE_BASE),
    .mask  (SLAVE_MASK),
    .hit   (dec_hit),
    .sel   (dec_sel),
    .onehot(dec_onehot)
  );
  assign start     = (state == IDLE) && bus.m_req;
  assign ready     = (state == ACCESS) && bus.s_ready[sel_q];
  assign tmo       = (state == ACCESS) && (cnt_q == CNT_LAST);
  assign rdata_sel = bus.s_rdata[int'(sel_q)*32 +: 32];
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = bus.m_req ? (dec_hit ? ACCESS : RESP) : IDLE;
    else if (state == ACCESS) state_nx = (ready || tmo) ? RESP : ACCESS;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= '0;
      sel_q      <= '0;
      cs_q       <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // Counter sits at zero outside ACCESS, so it is clear on every entry.
      cnt_q <= (state == ACCESS) ? cnt_q + 1'b1 : '0;
      if (start) begin
        addr_q  <= bus.m_addr;
        wdata_q <= bus.m_wdata;
        wr_q    <= {bus.m_write_w, bus.m_write_h, bus.m_write_b};
        sel_q   <= dec_sel;
        cs_q    <= dec_onehot;
        err_q   <= !dec_hit;
        if (!dec_hit) begin
          rdata_q    <= ERR_RDATA;
          err_addr_q <= bus.m_addr;
        end
      end
      // Ready wins over a timeout landing in the same cycle.
      if (ready || tmo) begin
        rdata_q <= ready ? rdata_sel : ERR_RDATA;
        err_q   <= !ready;
        if (!ready) err_addr_q <= addr_q;
      end
    end
  assign cs_act        = (state == ACCESS) ? cs_q : '0;
  assign bus.s_cs      = cs_act;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_write_w = wr_q[2] & |cs_act;
  assign bus.s_write_h = wr_q[1] & |cs_act;
  assign bus.s_write_b = wr_q[0] & |cs_act;
  assign bus.m_rdata   = rdata_q;
  assign bus.m_ack     = (state == RESP);
  assign bus.m_err     = (state == RESP) & err_q;
  assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_riscv_bus_fabric.sv
// tb_riscv_bus_fabric: directed self-checking bench for riscv_bus_fabric
module tb_riscv_bus_fabric;
  localparam int AW = 16;
  localparam int N  = 3;
  // dut: slave 0 RAM 4000/C000, slave 1 ROM 8000/8000, slave 2 PIO 2000/E000
  localparam logic [N*AW-1:0] BASE1 = {16'h2000, 16'h8000, 16'h4000};
  localparam logic [N*AW-1:0] MASK1 = {16'hE000, 16'h8000, 16'hC000};
  // dut2: slaves 0 and 1 both match 'h8000
  localparam logic [N*AW-1:0] BASE2 = {16'h0000, 16'h8000, 16'h8000};
  localparam logic [N*AW-1:0] MASK2 = {16'hE000, 16'hF000, 16'h8000};
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  riscv_bus_fabric_if #(.ADDR_BUS_WIDTH(AW), .NR_OF_SLAVES(N)) bus1 ();
  riscv_bus_fabric_if #(.ADDR_BUS_WIDTH(AW), .NR_OF_SLAVES(N)) bus2 ();
  riscv_bus_fabric #(
    .ADDR_BUS_WIDTH(AW), .NR_OF_SLAVES(N), .SLAVE_BASE(BASE1), .SLAVE_MASK(MASK1),
    .TIMEOUT_CNT_WIDTH(4), .ERR_RDATA(ERR_D)
  ) dut (.clk(clk), .rst(rst), .bus(bus1));
  riscv_bus_fabric #(
    .ADDR_BUS_WIDTH(AW), .NR_OF_SLAVES(N), .SLAVE_BASE(BASE2), .SLAVE_MASK(MASK2),
    .TIMEOUT_CNT_WIDTH(4), .ERR_RDATA(ERR_D)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  assign bus2.s_ready = bus2.s_cs;
  assign bus2.s_rdata = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  int          r_ack, r_cs, r_wr, r_nocs;
  logic [2:0]  r_seen, r_strb;
  logic [31:0] r_rdata, r_swdata;
  logic [15:0] r_saddr;
  logic        r_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  // One transfer on dut; the selected slave asserts ready on ACCESS cycle rdy_at (0 = never).
  // Cycle 1 is the cycle whose closing edge first samples m_req.
  task automatic xfer(input logic [15:0] a, input logic [31:0] wd, input logic [2:0] wr,
                      input int rdy_at, input logic [31:0] rd);
    int cyc, acc;
    @(negedge clk);
    bus1.m_req = 1'b1;
    bus1.m_addr = a;
    bus1.m_wdata = wd;
    {bus1.m_write_w, bus1.m_write_h, bus1.m_write_b} = wr;
    cyc = 1; acc = 0; r_ack = 0; r_cs = 0; r_wr = 0; r_nocs = 0;
    r_seen = '0; r_strb = '0; r_saddr = '0; r_swdata = '0; r_rdata = '0; r_err = 1'b0;
    while (r_ack == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus1.s_cs != '0) begin
        acc++;
        r_cs++;
        r_seen |= bus1.s_cs;
        if (acc == 1) begin
          r_strb = {bus1.s_write_w, bus1.s_write_h, bus1.s_write_b};
          r_saddr = bus1.s_addr;
          r_swdata = bus1.s_wdata;
        end
        if (bus1.s_write_w) r_wr++;
      end else if (bus1.s_write_w | bus1.s_write_h | bus1.s_write_b) r_nocs++;
      bus1.s_ready = (bus1.s_cs != '0 && acc == rdy_at) ? bus1.s_cs : '0;
      for (int i = 0; i < N; i++) bus1.s_rdata[i*32 +: 32] = bus1.s_cs[i] ? rd : 32'hBAD0_0000 + i;
      if (bus1.m_ack) begin
        r_ack = cyc;
        r_rdata = bus1.m_rdata;
        r_err = bus1.m_err;
        bus1.m_req = 1'b0;
        {bus1.m_write_w, bus1.m_write_h, bus1.m_write_b} = 3'b000;
      end
    end
    bus1.m_req = 1'b0;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int acks, pat;
    bus1.m_req = 1'b0; bus1.m_addr = '0; bus1.m_wdata = '0;
    {bus1.m_write_w, bus1.m_write_h, bus1.m_write_b} = 3'b000;
    bus1.s_ready = '0; bus1.s_rdata = '0;
    bus2.m_req = 1'b0; bus2.m_addr = '0; bus2.m_wdata = '0;
    {bus2.m_write_w, bus2.m_write_h, bus2.m_write_b} = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_rdata", bus1.m_rdata, 32'h0);
    chk("rst_ack_err", {bus1.m_ack, bus1.m_err}, 32'h0);
    chk("rst_err_addr", bus1.err_addr, 32'h0);
    chk("rst_s_cs", bus1.s_cs, 32'h0);
    chk("rst_s_addr", bus1.s_addr, 32'h0);
    chk("rst_s_wdata", bus1.s_wdata, 32'h0);
    chk("rst_strobes", {bus1.s_write_w, bus1.s_write_h, bus1.s_write_b}, 32'h0);
    rst = 1'b1;
    // ROM read, zero wait
    xfer(16'h8004, 32'h0, 3'b000, 1, 32'h0000_0013);
    chk("rom_ack_cyc", r_ack, 3);
    chk("rom_rdata", r_rdata, 32'h0000_0013);
    chk("rom_err", r_err, 0);
    chk("rom_cs", r_seen, 3'b010);
    chk("rom_cs_cyc", r_cs, 1);
    chk("rom_s_addr", r_saddr, 16'h8004);
    // RAM word write, two wait cycles
    xfer(16'h4010, 32'hA5A5_A5A5, 3'b100, 3, 32'h5A5A_0001);
    chk("ram_ack_cyc", r_ack, 5);
    chk("ram_err", r_err, 0);
    chk("ram_cs", r_seen, 3'b001);
    chk("ram_wr_cyc", r_wr, 3);
    chk("ram_strobe_nocs", r_nocs, 0);
    chk("ram_s_wdata", r_swdata, 32'hA5A5_A5A5);
    chk("ram_rdata", r_rdata, 32'h5A5A_0001);
    // ROM half write, one wait cycle
    xfer(16'h8100, 32'h0000_BEEF, 3'b010, 2, 32'h0000_0077);
    chk("hw_strobes", r_strb, 3'b010);
    chk("hw_ack_cyc", r_ack, 4);
    chk("hw_strobe_nocs", r_nocs, 0);
    // decode miss
    xfer(16'h1000, 32'h0, 3'b000, 1, 32'h0000_0099);
    chk("miss_ack_cyc", r_ack, 2);
    chk("miss_err", r_err, 1);
    chk("miss_rdata", r_rdata, ERR_D);
    chk("miss_err_addr", bus1.err_addr, 16'h1000);
    chk("miss_cs_cyc", r_cs, 0);
    // PIO never ready -> timeout
    xfer(16'h2000, 32'h0, 3'b000, 0, 32'h0000_0055);
    chk("tmo_cs_cyc", r_cs, 15);
    chk("tmo_ack_cyc", r_ack, 17);
    chk("tmo_err", r_err, 1);
    chk("tmo_rdata", r_rdata, ERR_D);
    chk("tmo_err_addr", bus1.err_addr, 16'h2000);
    chk("tmo_cs", r_seen, 3'b100);
    // PIO ready on the terminal cycle wins
    xfer(16'h2004, 32'h0, 3'b000, 15, 32'h0000_00F0);
    chk("late_cs_cyc", r_cs, 15);
    chk("late_ack_cyc", r_ack, 17);
    chk("late_err", r_err, 0);
    chk("late_rdata", r_rdata, 32'h0000_00F0);
    chk("late_err_addr", bus1.err_addr, 16'h2000);
    // overlapping masks on dut2, m_req held through RESP
    @(negedge clk);
    bus2.m_req = 1'b1;
    bus2.m_addr = 16'h8000;
    acks = 0;
    pat = 0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 2) chk("ovl_cs", bus2.s_cs, 3'b001);
      if (bus2.m_ack) begin
        acks++;
        pat |= 1 << c;
        if (c == 3) chk("ovl_rdata", bus2.m_rdata, 32'hC0DE_0000);
        if (c == 3) chk("ovl_err", bus2.m_err, 0);
      end
      if (c == 6) bus2.m_req = 1'b0;
    end
    chk("ovl_ack_count", acks, 2);
    chk("ovl_ack_pattern", pat, 32'h48);
    // reset in the middle of an ACCESS
    @(negedge clk);
    bus1.m_req = 1'b1;
    bus1.m_addr = 16'h2000;
    bus1.s_ready = '0;
    repeat (3) @(negedge clk);
    chk("mid_cs_pre", bus1.s_cs, 3'b100);
    rst = 1'b0;
    #1;
    chk("mid_cs", bus1.s_cs, 32'h0);
    chk("mid_ack_err", {bus1.m_ack, bus1.m_err}, 32'h0);
    chk("mid_err_addr", bus1.err_addr, 32'h0);
    chk("mid_rdata", bus1.m_rdata, 32'h0);
    bus1.m_req = 1'b0;
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus1.m_ack || bus1.s_cs != '0) acks++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus1.m_ack || bus1.s_cs != '0) acks++;
    end
    chk("mid_no_ack", acks, 0);
    // normal read after reset release
    xfer(16'h8008, 32'h0, 3'b000, 1, 32'h0000_0093);
    chk("post_ack_cyc", r_ack, 3);
    chk("post_rdata", r_rdata, 32'h0000_0093);
    chk("post_err", r_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
